// File: rtl/shift_fu_pkg.sv
// Shared types, opcode encodings and decode for the shift functional unit.
package shift_fu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 3;

    localparam logic [OP_W-1:0] OP_SLL  = 3'b000;
    localparam logic [OP_W-1:0] OP_SRL  = 3'b001;
    localparam logic [OP_W-1:0] OP_SRA  = 3'b010;
    localparam logic [OP_W-1:0] OP_SLLI = 3'b100;
    localparam logic [OP_W-1:0] OP_SRLI = 3'b101;
    localparam logic [OP_W-1:0] OP_SRAI = 3'b110;

    typedef struct packed {
        logic [DATA_W-1:0]  x;
        logic [SHAMT_W-1:0] s;
        logic               left;
        logic               log;
        logic               illegal;
    } shift_dec_t;

    localparam int unsigned DEC_W = $bits(shift_dec_t);

    // Illegal opcodes decode to an identity shift (left by zero) flagged illegal.
    function automatic shift_dec_t shift_decode(
        input logic [OP_W-1:0]    op,
        input logic [DATA_W-1:0]  a,
        input logic [SHAMT_W-1:0] b_amt,
        input logic [SHAMT_W-1:0] imm
    );
        shift_dec_t d;
        d.x       = a;
        d.s       = op[2] ? imm : b_amt;
        d.left    = 1'b1;
        d.log     = 1'b1;
        d.illegal = 1'b0;
        case (op)
            OP_SLL, OP_SLLI: begin
                d.left = 1'b1;
                d.log  = 1'b1;
            end
            OP_SRL, OP_SRLI: begin
                d.left = 1'b0;
                d.log  = 1'b1;
            end
            OP_SRA, OP_SRAI: begin
                d.left = 1'b0;
                d.log  = 1'b0;
            end
            default: begin
                d.s       = '0;
                d.left    = 1'b1;
                d.log     = 1'b1;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/shift_issue_stage_if.sv
// Instruction-in and shifter-out handshakes of the shift issue stage.
interface shift_issue_if #(
    parameter int unsigned TAG_W = 4
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [2:0]       IN_OP;
    logic [31:0]      IN_A;
    logic [31:0]      IN_B;
    logic [4:0]       IN_IMM;
    logic [TAG_W-1:0] IN_TAG;

    logic             SH_VALID;
    logic             SH_READY;
    logic [31:0]      SH_X;
    logic [4:0]       SH_S;
    logic             SH_LEFT;
    logic             SH_LOG;
    logic [TAG_W-1:0] SH_TAG;
    logic             SH_ILLEGAL;

    modport slave (
        input  IN_VALID, IN_OP, IN_A, IN_B, IN_IMM, IN_TAG, SH_READY,
        output IN_READY, SH_VALID, SH_X, SH_S, SH_LEFT, SH_LOG, SH_TAG, SH_ILLEGAL
    );

    modport master (
        output IN_VALID, IN_OP, IN_A, IN_B, IN_IMM, IN_TAG, SH_READY,
        input  IN_READY, SH_VALID, SH_X, SH_S, SH_LEFT, SH_LOG, SH_TAG, SH_ILLEGAL
    );
endinterface

// File: rtl/shift_op_fifo.sv
// Generic register FIFO; the head output holds the last popped entry while empty.
module shift_op_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_last;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = o_empty ? r_last : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_last   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/shift_issue_stage.sv
// Decodes shift instructions, queues decoded entries and presents the head to the shifter.
module shift_issue_stage
    import shift_fu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    shift_issue_if.slave      bus,
    output logic [CNT_W-1:0]  ISSUE_CNT,
    output logic [CNT_W-1:0]  ILL_CNT
);
    localparam int unsigned ENTRY_W = DEC_W + TAG_W;

    shift_dec_t         w_dec_in;
    shift_dec_t         w_dec_head;
    logic [ENTRY_W-1:0] w_entry_in;
    logic [ENTRY_W-1:0] w_entry_head;
    logic               w_full;
    logic               w_empty;
    logic               w_enq;
    logic               w_deq;
    logic               w_unused_b;

    logic [CNT_W-1:0]   r_issue_cnt;
    logic [CNT_W-1:0]   r_ill_cnt;

    assign w_unused_b = ^bus.IN_B[31:5];

    assign w_dec_in   = shift_decode(bus.IN_OP, bus.IN_A, bus.IN_B[4:0], bus.IN_IMM);
    assign w_entry_in = {w_dec_in, bus.IN_TAG};
    assign w_enq      = bus.IN_VALID && !w_full;
    assign w_deq      = !w_empty && bus.SH_READY;

    shift_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (w_enq),
        .i_pop   (w_deq),
        .i_data  (w_entry_in),
        .o_data  (w_entry_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_dec_head     = shift_dec_t'(w_entry_head[ENTRY_W-1 -: DEC_W]);

    assign bus.IN_READY   = !w_full;
    assign bus.SH_VALID   = !w_empty;
    assign bus.SH_X       = w_dec_head.x;
    assign bus.SH_S       = w_dec_head.s;
    assign bus.SH_LEFT    = w_dec_head.left;
    assign bus.SH_LOG     = w_dec_head.log;
    assign bus.SH_ILLEGAL = w_dec_head.illegal;
    assign bus.SH_TAG     = w_entry_head[TAG_W-1:0];

    // Issue count wraps; illegal count saturates.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_issue_cnt <= '0;
            r_ill_cnt   <= '0;
        end else if (w_deq) begin
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            if (w_dec_head.illegal && (r_ill_cnt != '1)) begin
                r_ill_cnt <= r_ill_cnt + CNT_W'(1);
            end
        end
    end

    assign ISSUE_CNT = r_issue_cnt;
    assign ILL_CNT   = r_ill_cnt;
endmodule
